bus_arbiter_2: RTL and testbench
================================

Name: bus_arbiter_2

Overview:
- Two-initiator to one-target arbiter for the shared 32-bit ren/wen/ready memory bus.
- Typical masters: CPU instruction fetch and data/DMA.
- Single device-side port drives the address-decoding bus hub upstream of peripherals.
- Round-robin with grant lock: the granted host owns the bus until the target returns ready.

Parameters:
- TIMEOUT_CYCLES, 255, cycles a granted transaction may wait for device_ready before forced completion (used only with BUS_ARBITER_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- host_address  in  64  two packed 32-bit addresses; host i at [i*32+31:i*32].
- host_data_write  in  64  packed write data.
- host_write_mask  in  8  packed byte masks; host i at [i*4+3:i*4].
- host_ren  in  2  per-host read request.
- host_wen  in  2  per-host write request.
- host_data_read  out  32  read data broadcast to both hosts; valid only with the matching host_ready bit.
- host_ready  out  2  per-host completion strobe.
- device_address  out  32  forwarded address.
- device_data_write  out  32  forwarded write data.
- device_write_mask  out  4  forwarded byte mask.
- device_ren  out  1  forwarded read request.
- device_wen  out  1  forwarded write request.
- device_data_read  in  32  target read data.
- device_ready  in  1  target completion.
- grant  out  2  one-hot current owner; 0 when idle.
- timeout_flag  out  1  sticky timeout indicator.

Behaviour:
- Request definition: req[i] = host_ren[i] | host_wen[i].
- Host contract: hold address, data and mask stable until host_ready[i].

Reset (async):
- state = IDLE, grant = 0, last_served = 1 (host 0 wins the first tie), timeout counter = 0, timeout_flag = 0.
- All outputs 0 during reset.

States:
- IDLE:
  - device_ren/wen forced 0.
  - device_address/data/mask carry the host 0 fields.
  - host_ready = 0.
  - If any req, register the winner and move to OWN0 or OWN1.
  - One req: that host wins.
  - Both req: the host != last_served wins.
- OWNi, combinational forwarding:
  - Host i address, data and mask go to the device.
  - device_ren = host_ren[i], device_wen = host_wen[i].
  - host_ready[i] = device_ready; other host_ready bit = 0.
  - host_data_read = device_data_read.
  - grant = one-hot i.
- OWNi, completion (device_ready = 1):
  - last_served <= i.
  - If req[1-i], go directly to OWN(1-i): back-to-back, no bubble.
  - Else go to IDLE.
  - req[i] is ignored in the completion cycle; the host has not yet dropped it.

Latency:
- From IDLE, a request reaches the device 1 cycle after first assertion.
- Ready propagates combinationally in the same cycle.

Boundary conditions:
- Abort: host i drops req in OWNi without ready (protocol violation). Go to IDLE next cycle; last_served unchanged.
- device_ready in IDLE: ignored; no host_ready asserted.
- ren and wen both high: both forwarded unchanged; the arbiter does not check this.
- Starvation: with both hosts requesting continuously, grants strictly alternate.
- Reset mid-transaction: immediate IDLE; device_ren/wen drop asynchronously.

Optional Feature:
- Macro BUS_ARBITER_TIMEOUT_EN.
- Enabled:
  - Counter increments each cycle in OWNi while device_ready = 0, and clears on any state change.
  - When the count reaches TIMEOUT_CYCLES:
    - assert host_ready[i] for that cycle with host_data_read = 32'hDEADBEEF;
    - force device_ren/wen to 0;
    - set timeout_flag (sticky until reset);
    - leave the state as on normal completion.
- Disabled: no counter; timeout_flag tied 0; a stuck target hangs the bus.

Decomposition:
- Package bus_pkg holds:
  - BUS_ADDR_W = 32, BUS_DATA_W = 32, BUS_MASK_W = 4;
  - arb_state_t enum {ARB_IDLE, ARB_OWN0, ARB_OWN1};
  - BUS_TIMEOUT_DATA = 32'hDEADBEEF.
- One combinational sub-module, rr_pick_2 (inputs req[1:0] and last_served; outputs winner and valid), reusable by a future N-way arbiter.

Test Plan:
- Host 0 reads 0x1000 alone; device_ready after 3 cycles with data 0xCAFEF00D. Expect:
  - device_ren high 1 cycle after request;
  - host_ready = 2'b01 in the ready cycle;
  - host_data_read = 0xCAFEF00D.
- Both hosts request at the same cycle from reset. Expect:
  - grant = 01 first;
  - on ready, grant switches straight to 10 the next cycle with no IDLE;
  - host_ready[1] never asserts during the host 0 transaction.
- Both hosts request continuously for 6 transactions, device_ready always 1 in OWN. Expect grant to alternate 01, 10, 01, 10, 01, 10.
- Host 1 writes 0x2000, data 0x11223344, mask 4'b0011. Expect the device to see exactly these values with wen = 1 and ren = 0.
- Assert rst mid-OWN1, asynchronously between clock edges. Expect grant, device_ren/wen and host_ready to go 0 immediately; after release, host 0 wins a tie.
- With BUS_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES = 8, device_ready never asserts. Expect:
  - host_ready[0] pulses with data 0xDEADBEEF on the cycle the count reaches 8;
  - timeout_flag = 1 and stays set;
  - the arbiter then services host 1.

Source files
------------

// File: rtl/bus_pkg.sv
// ============================================================================
// Module : bus_pkg
// Shared widths, arbiter state encoding and timeout read-data pattern.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package bus_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_MASK_W = 4;

  localparam logic [BUS_DATA_W-1:0] BUS_TIMEOUT_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_arbiter_2_if.sv
// ============================================================================
// Module : bus_arbiter_2_if
// Host-side and device-side bus bundle; slave = arbiter view, master = environment.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface bus_arbiter_2_if;
  import bus_pkg::*;

  logic [2*BUS_ADDR_W-1:0] host_address;
  logic [2*BUS_DATA_W-1:0] host_data_write;
  logic [2*BUS_MASK_W-1:0] host_write_mask;
  logic [1:0]              host_ren;
  logic [1:0]              host_wen;
  logic [BUS_DATA_W-1:0]   host_data_read;
  logic [1:0]              host_ready;
  logic [BUS_ADDR_W-1:0]   device_address;
  logic [BUS_DATA_W-1:0]   device_data_write;
  logic [BUS_MASK_W-1:0]   device_write_mask;
  logic                    device_ren;
  logic                    device_wen;
  logic [BUS_DATA_W-1:0]   device_data_read;
  logic                    device_ready;
  logic [1:0]              grant;
  logic                    timeout_flag;

  modport slave (
    input  host_address, host_data_write, host_write_mask, host_ren, host_wen,
    input  device_data_read, device_ready,
    output host_data_read, host_ready,
    output device_address, device_data_write, device_write_mask, device_ren, device_wen,
    output grant, timeout_flag
  );

  modport master (
    output host_address, host_data_write, host_write_mask, host_ren, host_wen,
    output device_data_read, device_ready,
    input  host_data_read, host_ready,
    input  device_address, device_data_write, device_write_mask, device_ren, device_wen,
    input  grant, timeout_flag
  );

endinterface

`default_nettype wire

// File: rtl/bus_arbiter_2_rr_pick_2.sv
// ============================================================================
// Module : rr_pick_2
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not last served.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_pick_2 (
  input  logic [1:0] req,
  input  logic       last_served,
  output logic       winner,
  output logic       valid
);

  assign valid  = |req;
  assign winner = (&req) ? ~last_served : req[1];

endmodule

`default_nettype wire

// File: rtl/bus_arbiter_2.sv
// ============================================================================
// Module : bus_arbiter_2
// Two-host round-robin arbiter with grant lock; optional watchdog via BUS_ARBITER_TIMEOUT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bus_arbiter_2
  import bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  bus_arbiter_2_if.slave  bus
);

  arb_state_t r_state;
  logic [1:0] r_grant;
  logic       r_last_served;

  logic [1:0] w_req;
  logic       w_own;
  logic       w_idx;
  logic       w_other;
  logic       w_win;
  logic       w_win_valid;
  logic       w_timeout;
  logic       w_timeout_flag;
  logic       w_done;

  logic [BUS_ADDR_W-1:0] w_dev_addr;
  logic [BUS_DATA_W-1:0] w_dev_wdata;
  logic [BUS_MASK_W-1:0] w_dev_mask;
  logic                  w_dev_ren;
  logic                  w_dev_wen;
  logic [1:0]            w_host_ready;
  logic [BUS_DATA_W-1:0] w_host_rdata;

  assign w_req   = bus.host_ren | bus.host_wen;
  assign w_own   = (r_state != ARB_IDLE);
  assign w_idx   = (r_state == ARB_OWN1);
  assign w_other = ~w_idx;
  assign w_done  = w_own & (bus.device_ready | w_timeout);

  rr_pick_2 u_pick (
    .req         (w_req),
    .last_served (r_last_served),
    .winner      (w_win),
    .valid       (w_win_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ARB_IDLE;
      r_grant       <= 2'b00;
      r_last_served <= 1'b1;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_win_valid) begin
            r_state <= w_win ? ARB_OWN1 : ARB_OWN0;
            r_grant <= onehot2(w_win);
          end
        end
        ARB_OWN0, ARB_OWN1: begin
          // The owner's request is still up in its completion cycle, so only the other host is looked at.
          if (w_done) begin
            r_last_served <= w_idx;
            if (w_req[w_other]) begin
              r_state <= w_other ? ARB_OWN1 : ARB_OWN0;
              r_grant <= onehot2(w_other);
            end else begin
              r_state <= ARB_IDLE;
              r_grant <= 2'b00;
            end
          end else if (!w_req[w_idx]) begin
            r_state <= ARB_IDLE;
            r_grant <= 2'b00;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          r_grant <= 2'b00;
        end
      endcase
    end
  end

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_CNT_W-1:0] r_to_cnt;
  logic               r_timeout_flag;

  assign w_timeout      = w_own && (r_to_cnt == c_CNT_W'(TIMEOUT_CYCLES));
  assign w_timeout_flag = r_timeout_flag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt       <= '0;
      r_timeout_flag <= 1'b0;
    end else begin
      if (w_own && !w_done && w_req[w_idx]) begin
        r_to_cnt <= r_to_cnt + c_CNT_W'(1);
      end else begin
        r_to_cnt <= '0;
      end
      if (w_timeout) begin
        r_timeout_flag <= 1'b1;
      end
    end
  end
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
  assign w_timeout        = 1'b0;
  assign w_timeout_flag   = 1'b0;
`endif

  always_comb begin
    w_dev_addr   = bus.host_address[BUS_ADDR_W-1:0];
    w_dev_wdata  = bus.host_data_write[BUS_DATA_W-1:0];
    w_dev_mask   = bus.host_write_mask[BUS_MASK_W-1:0];
    w_dev_ren    = 1'b0;
    w_dev_wen    = 1'b0;
    w_host_ready = 2'b00;
    w_host_rdata = '0;
    if (w_own) begin
      w_dev_addr   = w_idx ? bus.host_address[2*BUS_ADDR_W-1:BUS_ADDR_W]
                           : bus.host_address[BUS_ADDR_W-1:0];
      w_dev_wdata  = w_idx ? bus.host_data_write[2*BUS_DATA_W-1:BUS_DATA_W]
                           : bus.host_data_write[BUS_DATA_W-1:0];
      w_dev_mask   = w_idx ? bus.host_write_mask[2*BUS_MASK_W-1:BUS_MASK_W]
                           : bus.host_write_mask[BUS_MASK_W-1:0];
      w_dev_ren    = bus.host_ren[w_idx] & ~w_timeout;
      w_dev_wen    = bus.host_wen[w_idx] & ~w_timeout;
      w_host_ready[w_idx] = bus.device_ready | w_timeout;
      w_host_rdata = w_timeout ? BUS_TIMEOUT_DATA : bus.device_data_read;
    end
    // Everything reads zero while reset is held, including the idle host-0 passthrough.
    if (rst) begin
      w_dev_addr   = '0;
      w_dev_wdata  = '0;
      w_dev_mask   = '0;
      w_dev_ren    = 1'b0;
      w_dev_wen    = 1'b0;
      w_host_ready = 2'b00;
      w_host_rdata = '0;
    end
  end

  assign bus.device_address    = w_dev_addr;
  assign bus.device_data_write = w_dev_wdata;
  assign bus.device_write_mask = w_dev_mask;
  assign bus.device_ren        = w_dev_ren;
  assign bus.device_wen        = w_dev_wen;
  assign bus.host_ready        = w_host_ready;
  assign bus.host_data_read    = w_host_rdata;
  assign bus.grant             = rst ? 2'b00 : r_grant;
  assign bus.timeout_flag      = rst ? 1'b0 : w_timeout_flag;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter_2.sv
// ============================================================================
// Module : tb_bus_arbiter_2
// Directed stimulus with a scoreboard of expected host responses for bus_arbiter_2.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_bus_arbiter_2;

  typedef struct {
    logic        idx;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;
  exp_t sb[$];

  bus_arbiter_2_if bus ();

  bus_arbiter_2 #(.TIMEOUT_CYCLES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_resp(input logic idx, input logic [31:0] data);
    exp_t e;
    e.idx  = idx;
    e.data = data;
    sb.push_back(e);
  endtask

  // Monitor: every host_ready strobe must match the oldest expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.host_ready != 2'b00) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_ready", 64'(bus.host_ready), 64'd0);
        end else begin
          e = sb.pop_front();
          check("sb_ready_onehot", 64'(bus.host_ready), 64'(e.idx ? 2'b10 : 2'b01));
          check("sb_read_data", 64'(bus.host_data_read), 64'(e.data));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bus.host_address     = {32'h0000_2000, 32'h0000_1000};
    bus.host_data_write  = {32'h1122_3344, 32'h9999_9999};
    bus.host_write_mask  = 8'h3F;
    bus.host_ren         = 2'b00;
    bus.host_wen         = 2'b00;
    bus.device_data_read = 32'h0;
    bus.device_ready     = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_grant", 64'(bus.grant), 64'd0);
    check("rst_dev_addr", 64'(bus.device_address), 64'd0);
    check("rst_host_ready", 64'(bus.host_ready), 64'd0);
    check("rst_timeout_flag", 64'(bus.timeout_flag), 64'd0);
    tick();
    rst = 1'b0;

    // Host 0 reads 0x1000, ready on the third owned cycle
    bus.host_ren = 2'b01;
    @(negedge clk);
    check("t1_idle_ren", 64'(bus.device_ren), 64'd0);
    tick();
    @(negedge clk);
    check("t1_dev_ren", 64'(bus.device_ren), 64'd1);
    check("t1_dev_addr", 64'(bus.device_address), 64'h1000);
    check("t1_grant", 64'(bus.grant), 64'b01);
    tick();
    tick();
    bus.device_ready     = 1'b1;
    bus.device_data_read = 32'hCAFE_F00D;
    expect_resp(1'b0, 32'hCAFE_F00D);
    @(negedge clk);
    check("t1_host_ready", 64'(bus.host_ready), 64'b01);
    tick();
    bus.host_ren     = 2'b00;
    bus.device_ready = 1'b0;
    @(negedge clk);
    check("t1_back_idle", 64'(bus.grant), 64'd0);

    // Simultaneous requests from reset: host 0 first, host 1 back-to-back
    do_reset();
    bus.host_address = {32'h0000_4000, 32'h0000_3000};
    bus.host_ren     = 2'b11;
    tick();
    @(negedge clk);
    check("t2_grant0", 64'(bus.grant), 64'b01);
    check("t2_no_ready", 64'(bus.host_ready), 64'd0);
    tick();
    bus.device_ready     = 1'b1;
    bus.device_data_read = 32'hA0A0_A0A0;
    expect_resp(1'b0, 32'hA0A0_A0A0);
    @(negedge clk);
    check("t2_h1_ready_low", 64'(bus.host_ready[1]), 64'd0);
    tick();
    bus.host_ren         = 2'b10;
    bus.device_data_read = 32'hB1B1_B1B1;
    expect_resp(1'b1, 32'hB1B1_B1B1);
    @(negedge clk);
    check("t2_grant1_no_bubble", 64'(bus.grant), 64'b10);
    check("t2_dev_addr1", 64'(bus.device_address), 64'h4000);
    tick();
    bus.host_ren     = 2'b00;
    bus.device_ready = 1'b0;

    // Continuous contention: grants alternate, starting with host 0
    tick();
    bus.host_ren     = 2'b11;
    bus.device_ready = 1'b1;
    @(negedge clk);
    check("t3_idle_ready_ignored", 64'(bus.host_ready), 64'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      bus.device_data_read = 32'h5000_0000 + 32'(k);
      expect_resp(k[0], 32'h5000_0000 + 32'(k));
      @(negedge clk);
      check($sformatf("t3_grant_%0d", k), 64'(bus.grant), 64'(k[0] ? 2'b10 : 2'b01));
    end
    // Host 0 drops its request without ready: abort back to idle
    tick();
    bus.host_ren     = 2'b00;
    bus.device_ready = 1'b0;
    @(negedge clk);
    check("t3_abort_owner", 64'(bus.grant), 64'b01);
    tick();
    @(negedge clk);
    check("t3_abort_idle", 64'(bus.grant), 64'd0);

    // Host 1 write with distinct host 0 fields present
    bus.host_address    = {32'h0000_2000, 32'hAAAA_0000};
    bus.host_data_write = {32'h1122_3344, 32'h9999_9999};
    bus.host_write_mask = {4'b0011, 4'b1111};
    bus.host_wen        = 2'b10;
    tick();
    @(negedge clk);
    check("t4_addr", 64'(bus.device_address), 64'h2000);
    check("t4_data", 64'(bus.device_data_write), 64'h1122_3344);
    check("t4_mask", 64'(bus.device_write_mask), 64'b0011);
    check("t4_wen_ren", 64'({bus.device_wen, bus.device_ren}), 64'b10);
    tick();
    bus.device_ready     = 1'b1;
    bus.device_data_read = 32'h0;
    expect_resp(1'b1, 32'h0);
    tick();
    bus.host_wen     = 2'b00;
    bus.device_ready = 1'b0;

    // Asynchronous reset in the middle of a host 1 read
    bus.host_ren = 2'b10;
    tick();
    @(negedge clk);
    check("t5_grant_before", 64'(bus.grant), 64'b10);
    #2;
    rst              = 1'b1;
    bus.device_ready = 1'b1;
    #1;
    check("t5_grant_async", 64'(bus.grant), 64'd0);
    check("t5_ren_async", 64'(bus.device_ren), 64'd0);
    check("t5_ready_async", 64'(bus.host_ready), 64'd0);
    tick();
    rst              = 1'b0;
    bus.device_ready = 1'b0;
    bus.host_ren     = 2'b11;
    tick();
    @(negedge clk);
    check("t5_tie_host0", 64'(bus.grant), 64'b01);
    tick();
    bus.host_ren         = 2'b01;
    bus.device_ready     = 1'b1;
    bus.device_data_read = 32'h0D0D_0D0D;
    expect_resp(1'b0, 32'h0D0D_0D0D);
    tick();
    bus.host_ren     = 2'b00;
    bus.device_ready = 1'b0;
    @(negedge clk);
    check("t5_idle", 64'(bus.grant), 64'd0);

`ifdef BUS_ARBITER_TIMEOUT_EN
    // Stuck target: watchdog completes host 0 after 8 waiting cycles, then host 1 is served
    do_reset();
    bus.host_ren = 2'b11;
    tick();
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check($sformatf("t6_wait_%0d", c), 64'(bus.host_ready), 64'd0);
      tick();
    end
    expect_resp(1'b0, 32'hDEAD_BEEF);
    @(negedge clk);
    check("t6_ren_forced", 64'(bus.device_ren), 64'd0);
    tick();
    bus.host_ren         = 2'b10;
    bus.device_ready     = 1'b1;
    bus.device_data_read = 32'h1234_5678;
    expect_resp(1'b1, 32'h1234_5678);
    @(negedge clk);
    check("t6_grant1", 64'(bus.grant), 64'b10);
    check("t6_flag_set", 64'(bus.timeout_flag), 64'd1);
    tick();
    bus.host_ren     = 2'b00;
    bus.device_ready = 1'b0;
    @(negedge clk);
    check("t6_flag_sticky", 64'(bus.timeout_flag), 64'd1);
`else
    check("flag_tied_low", 64'(bus.timeout_flag), 64'd0);
`endif

    tick();
    @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
